// File: rtl/student_tlul_mem_pkg.sv
// Shared types for the TL-UL memory device: bus structs, opcodes, response entry.
// No logic; the request error decode is a pure function.
// Nothing here holds state or applies back-pressure.
package student_tlul_mem_pkg;

  localparam int RspDepth = 2;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [3:0]  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  typedef struct packed {
    tl_d_op_e    opcode;
    logic [1:0]  size;
    logic [7:0]  source;
    logic [31:0] data;
    logic        error;
  } rsp_entry_t;

  // A request is rejected if it falls outside the window, is oversized or
  // misaligned, uses an unsupported opcode, or is a full put whose mask does
  // not cover exactly the bytes implied by size and offset.
  function automatic logic req_is_err(
    input logic [2:0]  opcode,
    input logic [1:0]  size,
    input logic [31:0] addr,
    input logic [3:0]  mask,
    input logic [31:0] base,
    input logic [31:0] win_bytes
  );
    logic [32:0] diff;
    logic [3:0]  full_mask;
    logic        err;
    err  = 1'b0;
    // Borrow out of the 33-bit subtraction means the address is below base.
    diff = {1'b0, addr} - {1'b0, base};
    if (diff[32] || (diff[31:0] >= win_bytes)) err = 1'b1;
    if (size == 2'd3) err = 1'b1;
    if ((size == 2'd1) && addr[0]) err = 1'b1;
    if ((size == 2'd2) && (addr[1:0] != 2'd0)) err = 1'b1;
    if (!(opcode inside {PutFullData, PutPartialData, Get})) err = 1'b1;
    case (size)
      2'd0:    full_mask = 4'b0001 << addr[1:0];
      2'd1:    full_mask = 4'b0011 << addr[1:0];
      default: full_mask = 4'b1111;
    endcase
    if ((opcode == PutFullData) && (mask != full_mask)) err = 1'b1;
    return err;
  endfunction

endpackage

// File: rtl/student_tlul_mem_if.sv
// TL-UL host-to-device and device-to-host bundles as one interface.
// Pure wiring, zero latency.
// Back-pressure is carried inside the structs (a_ready / d_ready).
interface student_tlul_mem_if
  import student_tlul_mem_pkg::*;
();
  tl_h2d_t h2d;
  tl_d2h_t d2h;

  modport master (output h2d, input d2h);
  modport slave  (input h2d, output d2h);
endinterface

// File: rtl/student_tlul_rsp_fifo.sv
// Two-entry synchronous FIFO holding pending D-channel responses.
// Push visible at the head one cycle later; head is a registered slot.
// Push ignored when full, pop ignored when empty; push+pop together keeps count.
module student_tlul_rsp_fifo
  import student_tlul_mem_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push,
  input  rsp_entry_t push_dat,
  input  logic       pop,
  output rsp_entry_t head_dat,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);
  rsp_entry_t slots [RspDepth];
  logic       wr_ptr;
  logic       rd_ptr;
  logic       do_push;
  logic       do_pop;

  assign full     = (count == 2'(RspDepth));
  assign empty    = (count == 2'd0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = slots[rd_ptr];

  // Pointer and occupancy bookkeeping; reset flushes the queue.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  // Entry storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) slots[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/student_tlul_mem_dev.sv
// TL-UL device backed by a word-organised flop memory with byte writes.
// Accept at cycle N gives d_valid at N+1; writes commit at the accept edge.
// a_ready drops only when the 2-entry response queue is full (registered, no d_ready path).
module student_tlul_mem_dev
  import student_tlul_mem_pkg::*;
#(
  parameter int unsigned Depth    = 256,
  parameter logic [31:0] AddrBase = 32'h0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  student_tlul_mem_if.slave  tl,
  output logic [15:0]        err_count_o,
  output logic               busy_o
);
  localparam int          IdxW     = $clog2(Depth);
  localparam logic [31:0] WinBytes = 32'(Depth) << 2;

  logic [31:0] mem [Depth];

  tl_h2d_t     h2d;
  logic        a_ready;
  logic        accept;
  logic        req_err;
  logic        is_get;
  logic        is_put;
  logic [IdxW-1:0] idx;
  rsp_entry_t  push_dat;
  rsp_entry_t  head_dat;
  logic        full;
  logic        empty;
  logic [1:0]  count;
  logic        unused_bits;

  assign h2d         = tl.h2d;
  assign unused_bits = ^{h2d.a_param, count};

  assign a_ready = !full;
  assign accept  = h2d.a_valid && a_ready;
  assign is_get  = (h2d.a_opcode == Get);
  assign is_put  = (h2d.a_opcode == PutFullData) || (h2d.a_opcode == PutPartialData);
  assign req_err = req_is_err(h2d.a_opcode, h2d.a_size, h2d.a_address, h2d.a_mask,
                              AddrBase, WinBytes);
  assign idx     = IdxW'((h2d.a_address - AddrBase) >> 2);

  // Byte-masked write of legal puts; requests seen during reset have no effect.
  always_ff @(posedge clk_i) begin
    if (accept && !req_err && is_put && !rst_i) begin
      for (int b = 0; b < 4; b++) begin
        if (h2d.a_mask[b]) mem[idx][8*b +: 8] <= h2d.a_data[8*b +: 8];
      end
    end
  end

  // Build the response entry; Get data is the whole word, errors return zero.
  always_comb begin
    push_dat        = '0;
    push_dat.opcode = is_get ? AccessAckData : AccessAck;
    push_dat.size   = h2d.a_size;
    push_dat.source = h2d.a_source;
    push_dat.error  = req_err;
    if (is_get && !req_err) push_dat.data = mem[idx];
  end

  // Saturating count of error responses issued.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_count_o <= 16'h0;
    end else if (accept && req_err && (err_count_o != 16'hFFFF)) begin
      err_count_o <= err_count_o + 16'h1;
    end
  end

  student_tlul_rsp_fifo u_rsp_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (accept),
    .push_dat (push_dat),
    .pop      (h2d.d_ready),
    .head_dat (head_dat),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  assign busy_o = !empty;

  // D channel is driven straight from the queue head; unused fields are zero.
  always_comb begin
    tl.d2h          = '0;
    tl.d2h.d_valid  = !empty;
    tl.d2h.d_opcode = head_dat.opcode;
    tl.d2h.d_size   = head_dat.size;
    tl.d2h.d_source = head_dat.source;
    tl.d2h.d_data   = head_dat.data;
    tl.d2h.d_error  = head_dat.error;
    tl.d2h.a_ready  = a_ready;
  end

endmodule

// File: tb/tb_student_tlul_mem_dev.sv
// Directed bench for the TL-UL memory device: write/read, partial writes,
// back-pressure, error decode, streaming and reset mid-flight.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_student_tlul_mem_dev;
  import student_tlul_mem_pkg::*;

  localparam int unsigned Depth    = 256;
  localparam logic [31:0] AddrBase = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [15:0] err_count_o;
  logic        busy_o;
  int          total = 0;
  int          bad   = 0;

  student_tlul_mem_if tl_bus ();

  student_tlul_mem_dev #(.Depth(Depth), .AddrBase(AddrBase)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .tl          (tl_bus),
    .err_count_o (err_count_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                       input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src);
    tl_bus.h2d.a_valid   = 1'b1;
    tl_bus.h2d.a_opcode  = op;
    tl_bus.h2d.a_param   = 3'h0;
    tl_bus.h2d.a_size    = size;
    tl_bus.h2d.a_address = addr;
    tl_bus.h2d.a_mask    = mask;
    tl_bus.h2d.a_data    = data;
    tl_bus.h2d.a_source  = src;
  endtask

  // Present a request, wait (bounded) for a_ready, leave 1ns after the accept edge.
  task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] addr,
                       input logic [1:0] size, input logic [3:0] mask,
                       input logic [31:0] data, input logic [7:0] src);
    int n;
    drive(op, addr, size, mask, data, src);
    n = 0;
    while (tl_bus.d2h.a_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_a_ready"}, 32'(tl_bus.d2h.a_ready), 32'd1);
    tick();
    tl_bus.h2d.a_valid = 1'b0;
  endtask

  task automatic check_rsp(input string tag, input logic [2:0] op, input logic [7:0] src,
                           input logic chk_data, input logic [31:0] data, input logic err);
    chk({tag, "_d_valid"},  32'(tl_bus.d2h.d_valid),  32'd1);
    chk({tag, "_d_opcode"}, 32'(tl_bus.d2h.d_opcode), 32'(op));
    chk({tag, "_d_source"}, 32'(tl_bus.d2h.d_source), 32'(src));
    chk({tag, "_d_error"},  32'(tl_bus.d2h.d_error),  32'(err));
    if (chk_data) chk({tag, "_d_data"}, tl_bus.d2h.d_data, data);
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'h9E37_79B9 * 32'(i + 1);
  endfunction

  initial begin
    int stalls;
    int rsp_seen;
    int data_bad;

    tl_bus.h2d         = '0;
    tl_bus.h2d.d_ready = 1'b1;
    rst_i              = 1'b1;
    repeat (2) tick();

    // Reset state
    chk("rst_d_valid", 32'(tl_bus.d2h.d_valid), 32'd0);
    chk("rst_a_ready", 32'(tl_bus.d2h.a_ready), 32'd1);
    chk("rst_err_cnt", 32'(err_count_o),        32'd0);
    chk("rst_busy",    32'(busy_o),             32'd0);
    rst_i = 1'b0;
    tick();

    // Write then read, Get accepted the cycle after the Put
    issue("wr0", PutFullData, AddrBase + 32'h10, 2'd2, 4'hF, 32'hDEAD_BEEF, 8'd1);
    check_rsp("wr0", AccessAck, 8'd1, 1'b0, 32'h0, 1'b0);
    issue("rd0", Get, AddrBase + 32'h10, 2'd2, 4'hF, 32'h0, 8'd2);
    check_rsp("rd0", AccessAckData, 8'd2, 1'b1, 32'hDEAD_BEEF, 1'b0);

    // Partial writes: word then byte lanes 0 and 2, then a single byte at offset 1
    issue("fill", PutFullData, AddrBase + 32'h20, 2'd2, 4'hF, 32'h1122_3344, 8'd3);
    check_rsp("fill", AccessAck, 8'd3, 1'b0, 32'h0, 1'b0);
    issue("ppart", PutPartialData, AddrBase + 32'h20, 2'd2, 4'b0101, 32'hAABB_CCDD, 8'd4);
    check_rsp("ppart", AccessAck, 8'd4, 1'b0, 32'h0, 1'b0);
    issue("rd_part", Get, AddrBase + 32'h20, 2'd2, 4'hF, 32'h0, 8'd5);
    check_rsp("rd_part", AccessAckData, 8'd5, 1'b1, 32'h11BB_33DD, 1'b0);
    issue("wr_byte", PutFullData, AddrBase + 32'h21, 2'd0, 4'b0010, 32'h0000_EE00, 8'd6);
    check_rsp("wr_byte", AccessAck, 8'd6, 1'b0, 32'h0, 1'b0);
    issue("rd_byte", Get, AddrBase + 32'h21, 2'd0, 4'b0010, 32'h0, 8'd7);
    check_rsp("rd_byte", AccessAckData, 8'd7, 1'b1, 32'h11BB_EEDD, 1'b0);
    tick();

    // Back-pressure: three Gets with d_ready low, only two accepted
    tl_bus.h2d.d_ready = 1'b0;
    drive(Get, AddrBase + 32'h10, 2'd2, 4'hF, 32'h0, 8'd0);
    tick();
    check_rsp("bp0", AccessAckData, 8'd0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    drive(Get, AddrBase + 32'h20, 2'd2, 4'hF, 32'h0, 8'd1);
    tick();
    chk("bp_full_a_ready", 32'(tl_bus.d2h.a_ready), 32'd0);
    chk("bp_full_busy",    32'(busy_o),             32'd1);
    drive(Get, AddrBase + 32'h10, 2'd2, 4'hF, 32'h0, 8'd2);
    tick();
    chk("bp_hold_a_ready", 32'(tl_bus.d2h.a_ready),  32'd0);
    chk("bp_hold_source",  32'(tl_bus.d2h.d_source), 32'd0);
    tl_bus.h2d.d_ready = 1'b1;
    tick();
    check_rsp("bp1", AccessAckData, 8'd1, 1'b1, 32'h11BB_EEDD, 1'b0);
    chk("bp_release_a_ready", 32'(tl_bus.d2h.a_ready), 32'd1);
    tick();
    tl_bus.h2d.a_valid = 1'b0;
    check_rsp("bp2", AccessAckData, 8'd2, 1'b1, 32'hDEAD_BEEF, 1'b0);
    tick();
    chk("bp_drained", 32'(tl_bus.d2h.d_valid), 32'd0);

    // Error decode
    issue("e_oow", Get, AddrBase + 32'(4 * Depth), 2'd2, 4'hF, 32'h0, 8'h10);
    check_rsp("e_oow", AccessAckData, 8'h10, 1'b1, 32'h0, 1'b1);
    chk("e_oow_cnt", 32'(err_count_o), 32'd1);
    issue("e_mis", PutFullData, AddrBase + 32'h12, 2'd2, 4'hF, 32'h1234_5678, 8'h11);
    check_rsp("e_mis", AccessAck, 8'h11, 1'b1, 32'h0, 1'b1);
    chk("e_mis_cnt", 32'(err_count_o), 32'd2);
    issue("e_op", 3'h5, AddrBase + 32'h10, 2'd2, 4'hF, 32'h5555_5555, 8'h12);
    check_rsp("e_op", AccessAck, 8'h12, 1'b1, 32'h0, 1'b1);
    chk("e_op_cnt", 32'(err_count_o), 32'd3);
    issue("e_mask", PutFullData, AddrBase + 32'h10, 2'd0, 4'hF, 32'h6666_6666, 8'h13);
    check_rsp("e_mask", AccessAck, 8'h13, 1'b1, 32'h0, 1'b1);
    issue("e_below", Get, AddrBase - 32'h4, 2'd2, 4'hF, 32'h0, 8'h14);
    check_rsp("e_below", AccessAckData, 8'h14, 1'b1, 32'h0, 1'b1);
    chk("e_below_cnt", 32'(err_count_o), 32'd5);
    issue("rd_unchg", Get, AddrBase + 32'h10, 2'd2, 4'hF, 32'h0, 8'h15);
    check_rsp("rd_unchg", AccessAckData, 8'h15, 1'b1, 32'hDEAD_BEEF, 1'b0);
    issue("wr_last", PutFullData, AddrBase + 32'(4 * Depth - 4), 2'd2, 4'hF, 32'hCAFE_F00D, 8'h16);
    check_rsp("wr_last", AccessAck, 8'h16, 1'b0, 32'h0, 1'b0);
    issue("rd_last", Get, AddrBase + 32'(4 * Depth - 4), 2'd2, 4'hF, 32'h0, 8'h17);
    check_rsp("rd_last", AccessAckData, 8'h17, 1'b1, 32'hCAFE_F00D, 1'b0);
    chk("e_last_cnt", 32'(err_count_o), 32'd5);
    tick();

    // Streaming: 64 puts then 64 gets back to back
    stalls   = 0;
    rsp_seen = 0;
    data_bad = 0;
    for (int i = 0; i < 128; i++) begin
      if (i < 64) drive(PutFullData, AddrBase + 32'h100 + 32'(4 * i), 2'd2, 4'hF, pat(i), 8'(i));
      else        drive(Get, AddrBase + 32'h100 + 32'(4 * (i - 64)), 2'd2, 4'hF, 32'h0, 8'(i));
      if (tl_bus.d2h.a_ready !== 1'b1) stalls++;
      tick();
      if (tl_bus.d2h.d_valid === 1'b1 && tl_bus.d2h.d_source === 8'(i)) begin
        rsp_seen++;
        if (tl_bus.d2h.d_error !== 1'b0) data_bad++;
        if (i >= 64) begin
          if (tl_bus.d2h.d_opcode !== 3'(AccessAckData) || tl_bus.d2h.d_data !== pat(i - 64))
            data_bad++;
        end else if (tl_bus.d2h.d_opcode !== 3'(AccessAck)) begin
          data_bad++;
        end
      end
    end
    tl_bus.h2d.a_valid = 1'b0;
    tick();
    chk("stream_stalls",   32'(stalls),   32'd0);
    chk("stream_rsp_seen", 32'(rsp_seen), 32'd128);
    chk("stream_data_bad", 32'(data_bad), 32'd0);
    chk("stream_drained",  32'(tl_bus.d2h.d_valid), 32'd0);

    // Reset with two responses pending
    tl_bus.h2d.d_ready = 1'b0;
    drive(Get, AddrBase + 32'h10, 2'd2, 4'hF, 32'h0, 8'h30);
    tick();
    drive(Get, AddrBase + 32'h20, 2'd2, 4'hF, 32'h0, 8'h31);
    tick();
    tl_bus.h2d.a_valid = 1'b0;
    chk("mid_busy",    32'(busy_o),             32'd1);
    chk("mid_a_ready", 32'(tl_bus.d2h.a_ready), 32'd0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("mid_rst_d_valid", 32'(tl_bus.d2h.d_valid), 32'd0);
    chk("mid_rst_a_ready", 32'(tl_bus.d2h.a_ready), 32'd1);
    chk("mid_rst_err_cnt", 32'(err_count_o),        32'd0);
    chk("mid_rst_busy",    32'(busy_o),             32'd0);
    tl_bus.h2d.d_ready = 1'b1;
    issue("post_rd0", Get, AddrBase + 32'h20, 2'd2, 4'hF, 32'h0, 8'h40);
    check_rsp("post_rd0", AccessAckData, 8'h40, 1'b1, 32'h11BB_EEDD, 1'b0);
    issue("post_rd1", Get, AddrBase + 32'(4 * Depth - 4), 2'd2, 4'hF, 32'h0, 8'h41);
    check_rsp("post_rd1", AccessAckData, 8'h41, 1'b1, 32'hCAFE_F00D, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
